battleship_fleet_tracker: RTL and testbench

Registered, parametrised fleet state for one player's board. Ship placements are loaded into per-ship occupancy masks, torpedo shots are accepted through a valid/ready handshake, and each shot returns hit and sunk results a fixed one cycle later. The block also maintains a remaining-ship count and a game-over flag. It sits between the input/placement logic and the segment display driver, and drives `board` directly.

---
 rtl/battleship_fleet_tracker.sv | 168 ++++++++++++++++
 tb/tb_battleship_fleet_tracker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/battleship_fleet_tracker.sv
// Fleet state for one player's board: ship placement, torpedo resolution, ships-left and game-over.
// Define BATTLESHIP_SHOT_HISTORY_EN to add the shot_map / result_repeat outputs.
module battleship_fleet_tracker #(
  parameter int CELLS = 28,
  parameter int SHIPS = 3,
  parameter int IDX_W = $clog2(SHIPS),
  parameter int CNT_W = $clog2(SHIPS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [CELLS-1:0] load_mask,
  input  logic             start,
  input  logic             fire_valid,
  output logic             fire_ready,
  input  logic [CELLS-1:0] fire_mask,
  output logic             result_valid,
  output logic             result_hit,
  output logic [SHIPS-1:0] result_sunk,
  output logic             load_err,
  output logic [CELLS-1:0] board,
  output logic [CNT_W-1:0] ships_left,
  output logic             game_over
`ifdef BATTLESHIP_SHOT_HISTORY_EN
  ,
  output logic [CELLS-1:0] shot_map,
  output logic             result_repeat
`endif
);

  typedef enum logic [1:0] {SETUP, ARMED, RESULT, OVER} state_t;

  state_t                       state_q, state_d;
  logic [SHIPS-1:0][CELLS-1:0]  masks_q, masks_d;
  logic [CELLS-1:0]             board_q, board_d;
  logic [CNT_W-1:0]             shipsLeft_q, shipsLeft_d;
  logic                         fireReady_q, gameOver_q;
  logic                         resultValid_q, resultValid_d;
  logic                         resultHit_q, resultHit_d;
  logic [SHIPS-1:0]             resultSunk_q, resultSunk_d;
  logic                         loadErr_q, loadErr_d;
  logic [CELLS-1:0]             boardOld;
  logic                         loadBad;
`ifdef BATTLESHIP_SHOT_HISTORY_EN
  logic [CELLS-1:0]             shotMap_q, shotMap_d;
  logic                         resultRepeat_q, resultRepeat_d;
`endif

  // Loads are applied before the start check so a same-cycle start sees the new count.
  always_comb begin
    state_d       = state_q;
    masks_d       = masks_q;
    loadErr_d     = 1'b0;
    resultValid_d = 1'b0;
    resultHit_d   = 1'b0;
    resultSunk_d  = '0;
    boardOld      = '0;
    loadBad       = 1'b0;
`ifdef BATTLESHIP_SHOT_HISTORY_EN
    shotMap_d       = shotMap_q;
    resultRepeat_d  = 1'b0;
`endif
    for (int i = 0; i < SHIPS; i++) begin
      boardOld = boardOld | masks_q[i];
    end

    loadBad = (load_mask == '0) || (int'(load_idx) >= SHIPS);
    for (int i = 0; i < SHIPS; i++) begin
      if ((IDX_W'(i) != load_idx) && ((masks_q[i] & load_mask) != '0)) begin
        loadBad = 1'b1;
      end
    end

    case (state_q)
      SETUP: begin
        if (load_valid) begin
          if (loadBad) begin
            loadErr_d = 1'b1;
          end else begin
            for (int i = 0; i < SHIPS; i++) begin
              if (IDX_W'(i) == load_idx) masks_d[i] = load_mask;
            end
          end
        end
      end
      ARMED: begin
        if (fire_valid) begin
          state_d       = RESULT;
          resultValid_d = 1'b1;
          resultHit_d   = (boardOld & fire_mask) != '0;
          for (int i = 0; i < SHIPS; i++) begin
            masks_d[i]      = masks_q[i] & ~fire_mask;
            resultSunk_d[i] = (masks_q[i] != '0) && (masks_d[i] == '0);
          end
`ifdef BATTLESHIP_SHOT_HISTORY_EN
          resultRepeat_d = (fire_mask & ~shotMap_q) == '0;
          shotMap_d      = shotMap_q | fire_mask;
          if (resultRepeat_d) resultHit_d = 1'b0;
`endif
        end
      end
      RESULT:  state_d = (shipsLeft_q == '0) ? OVER : ARMED;
      default: state_d = OVER;
    endcase

    board_d     = '0;
    shipsLeft_d = '0;
    for (int i = 0; i < SHIPS; i++) begin
      board_d = board_d | masks_d[i];
      if (masks_d[i] != '0) shipsLeft_d = shipsLeft_d + CNT_W'(1);
    end

    if ((state_q == SETUP) && start) begin
      if (shipsLeft_d == '0) loadErr_d = 1'b1;
      else                   state_d   = ARMED;
    end
  end

  // All outputs are registered; status flags follow the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SETUP;
      masks_q       <= '0;
      board_q       <= '0;
      shipsLeft_q   <= '0;
      fireReady_q   <= 1'b0;
      gameOver_q    <= 1'b0;
      resultValid_q <= 1'b0;
      resultHit_q   <= 1'b0;
      resultSunk_q  <= '0;
      loadErr_q     <= 1'b0;
`ifdef BATTLESHIP_SHOT_HISTORY_EN
      shotMap_q      <= '0;
      resultRepeat_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      masks_q       <= masks_d;
      board_q       <= board_d;
      shipsLeft_q   <= shipsLeft_d;
      fireReady_q   <= (state_d == ARMED);
      gameOver_q    <= (state_d == OVER);
      resultValid_q <= resultValid_d;
      resultHit_q   <= resultHit_d;
      resultSunk_q  <= resultSunk_d;
      loadErr_q     <= loadErr_d;
`ifdef BATTLESHIP_SHOT_HISTORY_EN
      shotMap_q      <= shotMap_d;
      resultRepeat_q <= resultRepeat_d;
`endif
    end
  end

  assign fire_ready   = fireReady_q;
  assign result_valid = resultValid_q;
  assign result_hit   = resultHit_q;
  assign result_sunk  = resultSunk_q;
  assign load_err     = loadErr_q;
  assign board        = board_q;
  assign ships_left   = shipsLeft_q;
  assign game_over    = gameOver_q;
`ifdef BATTLESHIP_SHOT_HISTORY_EN
  assign shot_map      = shotMap_q;
  assign result_repeat = resultRepeat_q;
`endif

endmodule

// File: tb/tb_battleship_fleet_tracker.sv
// Directed self-checking bench for battleship_fleet_tracker with hand-computed expectations.
module tb_battleship_fleet_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [1:0]  load_idx;
  logic [27:0] load_mask;
  logic        start;
  logic        fire_valid;
  logic        fire_ready;
  logic [27:0] fire_mask;
  logic        result_valid;
  logic        result_hit;
  logic [2:0]  result_sunk;
  logic        load_err;
  logic [27:0] board;
  logic [1:0]  ships_left;
  logic        game_over;
`ifdef BATTLESHIP_SHOT_HISTORY_EN
  logic [27:0] shot_map;
  logic        result_repeat;
`endif

  int errors = 0;
  int checks = 0;

  battleship_fleet_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_idx(load_idx), .load_mask(load_mask),
    .start(start),
    .fire_valid(fire_valid), .fire_ready(fire_ready), .fire_mask(fire_mask),
    .result_valid(result_valid), .result_hit(result_hit), .result_sunk(result_sunk),
    .load_err(load_err), .board(board), .ships_left(ships_left), .game_over(game_over)
`ifdef BATTLESHIP_SHOT_HISTORY_EN
    , .shot_map(shot_map), .result_repeat(result_repeat)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hold the given inputs across exactly one rising edge, then sample 1 time unit later.
  task automatic applyStimulus(input logic lv, input logic [1:0] idx, input logic [27:0] lm,
                               input logic st, input logic fv, input logic [27:0] fm);
    load_valid = lv; load_idx = idx; load_mask = lm;
    start = st; fire_valid = fv; fire_mask = fm;
    @(posedge clk);
    #1;
    load_valid = 1'b0; start = 1'b0; fire_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b0, 28'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_idx = '0; load_mask = '0;
    start = 1'b0; fire_valid = 1'b0; fire_mask = '0;

    doReset();
    checkOutput("rst outputs", 32'({board, ships_left, fire_ready, result_valid, result_hit,
                result_sunk, load_err, game_over}), 32'h0);

    applyStimulus(1'b0, 2'd0, 28'h0, 1'b1, 1'b0, 28'h0);
    checkOutput("empty start err", 32'(load_err), 32'h1);
    checkOutput("empty start stays setup", 32'(fire_ready), 32'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b0, 28'h0);
    checkOutput("err one cycle", 32'(load_err), 32'h0);

    applyStimulus(1'b1, 2'd0, 28'h3, 1'b0, 1'b0, 28'h0);
    checkOutput("load0 board", 32'(board), 32'h3);
    applyStimulus(1'b1, 2'd0, 28'h7, 1'b0, 1'b0, 28'h0);
    checkOutput("reload board", 32'(board), 32'h7);
    checkOutput("reload no err", 32'(load_err), 32'h0);
    checkOutput("reload count", 32'(ships_left), 32'h1);

    applyStimulus(1'b1, 2'd1, 28'h6, 1'b0, 1'b0, 28'h0);
    checkOutput("overlap err", 32'(load_err), 32'h1);
    checkOutput("overlap board", 32'(board), 32'h7);
    applyStimulus(1'b1, 2'd3, 28'h100, 1'b0, 1'b0, 28'h0);
    checkOutput("bad idx err", 32'(load_err), 32'h1);
    checkOutput("bad idx board", 32'(board), 32'h7);
    applyStimulus(1'b1, 2'd2, 28'h0, 1'b0, 1'b0, 28'h0);
    checkOutput("zero mask err", 32'(load_err), 32'h1);

    // Load and start together: start must see the freshly loaded ship
    applyStimulus(1'b1, 2'd1, 28'h70, 1'b1, 1'b0, 28'h0);
    checkOutput("armed board", 32'(board), 32'h77);
    checkOutput("armed count", 32'(ships_left), 32'h2);
    checkOutput("armed ready", 32'(fire_ready), 32'h1);
    checkOutput("armed no err", 32'(load_err), 32'h0);

    applyStimulus(1'b1, 2'd2, 28'h800, 1'b1, 1'b0, 28'h0);
    checkOutput("load ignored armed", 32'(board), 32'h77);
    checkOutput("load ignored err", 32'(load_err), 32'h0);

    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h100);
    checkOutput("miss result", 32'({result_valid, result_hit, result_sunk}), 32'b10000);
    checkOutput("miss ready low", 32'(fire_ready), 32'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h7);
    checkOutput("result one cycle", 32'(result_valid), 32'h0);
    checkOutput("ready returns", 32'(fire_ready), 32'h1);
    checkOutput("fire in result ignored", 32'(board), 32'h77);

    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h3);
    checkOutput("hit result", 32'({result_valid, result_hit, result_sunk}), 32'b11000);
    checkOutput("hit board", 32'(board), 32'h74);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b0, 28'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h4);
    checkOutput("sink0 result", 32'({result_valid, result_hit, result_sunk}), 32'b11001);
    checkOutput("sink0 count", 32'(ships_left), 32'h1);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b0, 28'h0);
    checkOutput("not over yet", 32'({game_over, fire_ready}), 32'b01);

    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h70);
    checkOutput("sink1 result", 32'({result_valid, result_hit, result_sunk}), 32'b11010);
    checkOutput("sink1 count", 32'(ships_left), 32'h0);
    checkOutput("sink1 board", 32'(board), 32'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b0, 28'h0);
    checkOutput("game over", 32'({game_over, fire_ready}), 32'b10);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h1);
    checkOutput("over rejects fire", 32'(result_valid), 32'h0);
    checkOutput("over sticks", 32'(game_over), 32'h1);

    // Three ships sunk by one multi-cell shot
    doReset();
    applyStimulus(1'b1, 2'd0, 28'h1, 1'b0, 1'b0, 28'h0);
    applyStimulus(1'b1, 2'd1, 28'h2, 1'b0, 1'b0, 28'h0);
    applyStimulus(1'b1, 2'd2, 28'h4, 1'b1, 1'b0, 28'h0);
    checkOutput("three count", 32'(ships_left), 32'h3);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h7);
    checkOutput("multi sunk", 32'({result_valid, result_hit, result_sunk}), 32'b11111);
    checkOutput("multi count", 32'(ships_left), 32'h0);

    // Reset asserted during the RESULT cycle discards the result
    doReset();
    applyStimulus(1'b1, 2'd0, 28'h1, 1'b1, 1'b0, 28'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h1);
    checkOutput("pre-reset valid", 32'(result_valid), 32'h1);
    doReset();
    checkOutput("mid-result reset", 32'({board, ships_left, fire_ready, result_valid, result_hit,
                result_sunk, load_err, game_over}), 32'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b1, 1'b0, 28'h0);
    checkOutput("back in setup", 32'({load_err, fire_ready}), 32'b10);

`ifdef BATTLESHIP_SHOT_HISTORY_EN
    doReset();
    applyStimulus(1'b1, 2'd0, 28'h3, 1'b1, 1'b0, 28'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h1);
    checkOutput("first shot", 32'({result_valid, result_hit, result_repeat}), 32'b110);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b0, 28'h0);
    applyStimulus(1'b0, 2'd0, 28'h0, 1'b0, 1'b1, 28'h1);
    checkOutput("repeat shot", 32'({result_valid, result_hit, result_repeat}), 32'b101);
    checkOutput("shot map", 32'(shot_map), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
